// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot decoder with enable. It has two modes: direct
// decode of sel, or an auto-scan that walks the outputs with a fixed dwell time.
module decoder_scan #(
    parameter int N          = 3,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [N-1:0]      sel,
    input  logic              load,
    output logic [2**N-1:0]   out,
    output logic [N-1:0]      idx,
    output logic              wrap
);
    localparam int              OUTS  = 2**N;
    localparam int              DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DMAX  = DW'(DIV - 1);
    localparam logic [OUTS-1:0] INACT = {OUTS{ACTIVE_LOW != 0}};

    logic [N-1:0]    r_idx;
    logic [DW-1:0]   r_dwell;
    logic            r_wrap;
    logic [OUTS-1:0] r_out;

    logic [N-1:0]    w_idx_n;
    logic [DW-1:0]   w_dwell_n;
    logic            w_wrap_n;
    logic [OUTS-1:0] w_dec;

    // A single next-index value drives both idx and out, so they can never disagree.
    always_comb begin
        w_idx_n   = r_idx;
        w_dwell_n = r_dwell;
        w_wrap_n  = 1'b0;
        if (!mode || load) begin
            w_idx_n   = sel;
            w_dwell_n = '0;
        end else if (r_dwell == DMAX) begin
            w_dwell_n = '0;
            w_idx_n   = r_idx + N'(1);
            w_wrap_n  = &r_idx;
        end else begin
            w_dwell_n = r_dwell + DW'(1);
        end
    end

    for (genvar g = 0; g < OUTS; g++) begin : g_dec
        assign w_dec[g] = (w_idx_n == N'(g)) ^ (ACTIVE_LOW != 0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_dwell <= '0;
            r_wrap  <= 1'b0;
            r_out   <= INACT;
        end else if (!en) begin
            r_out  <= INACT;
            r_wrap <= 1'b0;
        end else begin
            r_idx   <= w_idx_n;
            r_dwell <= w_dwell_n;
            r_wrap  <= w_wrap_n;
            r_out   <= w_dec;
        end
    end

    assign out  = r_out;
    assign idx  = r_idx;
    assign wrap = r_wrap;
endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan. Three instances share one stimulus stream: DIV=4,
// DIV=1, and ACTIVE_LOW=1. Each is checked against a behavioural model.
module tb_decoder_scan;
    logic       clk = 1'b0;
    logic       rst_n, en, mode, load;
    logic [2:0] sel;
    logic [2:0][7:0] d_out;
    logic [2:0][2:0] d_idx;
    logic [2:0]      d_wrap;

    int errors = 0;
    int checks = 0;

    int   DIV_C[3] = '{4, 1, 4};
    int   AL_C[3]  = '{0, 0, 1};
    int   m_idx[3];
    int   m_dw[3];
    logic m_wrap[3];
    logic [7:0] m_out[3];
    logic [7:0] one;

    always #5 clk = ~clk;

    decoder_scan #(.N(3), .DIV(4), .ACTIVE_LOW(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .out(d_out[0]), .idx(d_idx[0]), .wrap(d_wrap[0]));
    decoder_scan #(.N(3), .DIV(1), .ACTIVE_LOW(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .out(d_out[1]), .idx(d_idx[1]), .wrap(d_wrap[1]));
    decoder_scan #(.N(3), .DIV(4), .ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
        .out(d_out[2]), .idx(d_idx[2]), .wrap(d_wrap[2]));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The model works from the scan rules directly: the index moves every DIV
    // enabled cycles, wraps mod 8, and the output is 1<<idx.
    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            if (!rst_n) begin
                m_idx[c] = 0; m_dw[c] = 0; m_wrap[c] = 1'b0;
                m_out[c] = (AL_C[c] != 0) ? 8'hFF : 8'h00;
            end else if (!en) begin
                m_wrap[c] = 1'b0;
                m_out[c]  = (AL_C[c] != 0) ? 8'hFF : 8'h00;
            end else begin
                m_wrap[c] = 1'b0;
                if (!mode || load) begin
                    m_idx[c] = int'(sel); m_dw[c] = 0;
                end else if (m_dw[c] == DIV_C[c] - 1) begin
                    m_wrap[c] = (m_idx[c] == 7);
                    m_idx[c]  = (m_idx[c] + 1) % 8;
                    m_dw[c]   = 0;
                end else begin
                    m_dw[c]++;
                end
                m_out[c] = 8'(1 << m_idx[c]);
                if (AL_C[c] != 0) m_out[c] = ~m_out[c];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("out%0d", c),  d_out[c],        m_out[c]);
            chk($sformatf("idx%0d", c),  8'(d_idx[c]),    8'(m_idx[c]));
            chk($sformatf("wrap%0d", c), 8'(d_wrap[c]),   8'(m_wrap[c]));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'd5; load = 1'b0;
        // Reset holds outputs inactive, then direct decode follows one cycle later
        step(); step();
        chk("rst_out0", d_out[0], 8'h00);
        chk("rst_out2", d_out[2], 8'hFF);
        rst_n = 1'b1;
        step();
        chk("post_rst_out", d_out[0], 8'h20);
        chk("post_rst_idx", 8'(d_idx[0]), 8'd5);

        // Direct sweep
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step();
            one = 8'h01;
            chk("direct_out", d_out[0], one << s);
        end

        // Scan from 6 through wrap
        mode = 1'b1; load = 1'b1; sel = 3'd6;
        step();
        chk("scan_load_out", d_out[0], 8'h40);
        load = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 4) chk("scan_k4_out", d_out[0], 8'h80);
            if (k == 8) begin
                chk("scan_k8_out", d_out[0], 8'h01);
                chk("scan_k8_wrap", 8'(d_wrap[0]), 8'd1);
            end
        end

        // Load wins over an advance due on the same edge
        load = 1'b1; sel = 3'd0;
        step();
        load = 1'b0;
        step(); step(); step();
        load = 1'b1; sel = 3'd3;
        step();
        chk("ldpri_out", d_out[0], 8'h08);
        chk("ldpri_wrap", 8'(d_wrap[0]), 8'd0);
        load = 1'b0;
        step(); step(); step();
        chk("ldpri_hold", 8'(d_idx[0]), 8'd3);
        step();
        chk("ldpri_adv", 8'(d_idx[0]), 8'd4);

        // Enable freeze mid-dwell
        load = 1'b1; sel = 3'd2;
        step();
        load = 1'b0;
        step(); step();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("freeze_out", d_out[0], 8'h00);
        end
        en = 1'b1;
        step();
        chk("resume_out", d_out[0], 8'h04);
        step();
        chk("resume_idx", 8'(d_idx[0]), 8'd3);

        // Active-low polarity and mid-run reset
        load = 1'b1; sel = 3'd1;
        step();
        chk("al_idx1", d_out[2], 8'hFD);
        load = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("al_rst", d_out[2], 8'hFF);
        rst_n = 1'b1;
        step(); step(); step();
        chk("al_dwell_restart", d_out[2], 8'hFE);
        step();
        chk("al_adv", d_out[2], 8'hFD);

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            rst_n = ($urandom % 50) != 0;
            en    = ($urandom % 8) != 0;
            mode  = ($urandom % 5) != 0;
            load  = ($urandom % 12) == 0;
            sel   = 3'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
